// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined RISC-V immediate generator: format enum,
// opcode constants and the decoded record carried through the skid buffer.
package imm_gen_pkg;

  localparam int XLEN_MAX = 64;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;

  // imm is sized for the widest core; narrower builds use the low XLEN bits.
  typedef struct packed {
    logic [31:0]          inst;
    logic [XLEN_MAX-1:0]  imm;
    imm_fmt_e             fmt;
    logic                 illegal;
  } imm_rec_t;

  // funct3 001 (SLLI) and 101 (SRLI/SRAI)
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return f3[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/imm_gen_if.sv
// Fetch-side and decode-side valid/ready channels of the immediate generator.
interface imm_gen_if
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_imm;
  imm_fmt_e        out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_inst, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_inst, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decode of one 32-bit instruction word for RV32I/RV64I.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] i_inst,
  output imm_rec_t    o_rec
);
  localparam int SHAMT_W = $clog2(XLEN);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode: XLEN must be 32 or 64");
  end

  logic [6:0]        w_op;
  logic [2:0]        w_f3;
  logic              w_shift;
  logic              w_hi_bad;
  logic signed [31:0] w_i, w_s, w_b, w_j;
  logic [31:0]       w_u;
  logic [XLEN-1:0]   w_imm;
  imm_fmt_e          w_fmt;
  logic              w_ill;

  assign w_op    = i_inst[6:0];
  assign w_f3    = i_inst[14:12];
  assign w_shift = is_shift_f3(w_f3);
  // Left shifts need inst[31:26]==0; right shifts also allow the SRAI bit 30.
  assign w_hi_bad = w_f3[2] ? (|{i_inst[31], i_inst[29:26]}) : (|i_inst[31:26]);

  assign w_i = 32'($signed(i_inst[31:20]));
  assign w_s = 32'($signed({i_inst[31:25], i_inst[11:7]}));
  assign w_b = 32'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}));
  assign w_j = 32'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}));
  assign w_u = {i_inst[31:12], 12'b0};

  always_comb begin
    w_fmt = FMT_NONE;
    w_imm = '0;
    w_ill = 1'b0;
    case (w_op)
      OPC_LOAD, OPC_JALR: begin
        w_fmt = FMT_I;
        w_imm = XLEN'(w_i);
      end
      OPC_OP_IMM: begin
        if (w_shift) begin
          w_fmt = FMT_SHAMT;
          w_imm = XLEN'(i_inst[20 +: SHAMT_W]);
          w_ill = w_hi_bad || (XLEN == 32 && i_inst[25]);
        end else begin
          w_fmt = FMT_I;
          w_imm = XLEN'(w_i);
        end
      end
      OPC_OP_IMM32: begin
        if (XLEN == 64) begin
          if (w_shift) begin
            w_fmt = FMT_SHAMT;
            w_imm = XLEN'(i_inst[24:20]);
            w_ill = w_hi_bad || i_inst[25];
          end else begin
            w_fmt = FMT_I;
            w_imm = XLEN'(w_i);
          end
        end
      end
      OPC_STORE:  begin w_fmt = FMT_S; w_imm = XLEN'(w_s); end
      OPC_BRANCH: begin w_fmt = FMT_B; w_imm = XLEN'(w_b); end
      OPC_JAL:    begin w_fmt = FMT_J; w_imm = XLEN'(w_j); end
      OPC_LUI, OPC_AUIPC: begin
        w_fmt = FMT_U;
        w_imm = XLEN'($signed(w_u));
      end
      default: ;
    endcase
    if (w_ill) w_imm = '0;
  end

  assign o_rec.inst    = i_inst;
  assign o_rec.imm     = XLEN_MAX'(w_imm);
  assign o_rec.fmt     = w_fmt;
  assign o_rec.illegal = w_ill;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode feeding a 2-entry skid buffer
// (output register + skid register) with synchronous flush.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  imm_gen_if.slave bus
);
  imm_rec_t w_dec;
  imm_rec_t r_out, r_skid;
  logic     r_out_vld, r_skid_vld;
  logic     w_accept, w_out_free;
  logic     w_unused;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .i_inst (bus.in_inst),
    .o_rec  (w_dec)
  );

  // Ready comes from skid state only; rst/flush just block the accept.
  assign bus.in_ready = !r_skid_vld && !rst && !flush;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_out_free   = !r_out_vld || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (flush) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_vld) begin
        r_out      <= r_skid;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else begin
        r_out_vld <= w_accept;
        if (w_accept) r_out <= w_dec;
      end
    end else if (w_accept) begin
      r_skid     <= w_dec;
      r_skid_vld <= 1'b1;
    end
  end

  assign bus.out_valid   = r_out_vld;
  assign bus.out_inst    = r_out.inst;
  assign bus.out_imm     = r_out.imm[XLEN-1:0];
  assign bus.out_fmt     = r_out.fmt;
  assign bus.out_illegal = r_out.illegal;
  assign w_unused        = ^r_out.imm;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance on one clock.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic clk, rst, flush;
  int   n_err = 0;
  int   n_chk = 0;

  imm_gen_if #(.XLEN(32)) b32 ();
  imm_gen_if #(.XLEN(64)) b64 ();

  imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));
  imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int N32 = 11;
  localparam logic [31:0] T32_INST [N32] = '{
    32'hFFF00093, 32'h4030D093, 32'h40000093, 32'hFE000EE3, 32'h00000033, 32'h02009093,
    32'hFE20AE23, 32'hFFFFF06F, 32'h2030D093, 32'hFFF0809B, 32'h80000537};
  localparam logic [31:0] T32_IMM [N32] = '{
    32'hFFFFFFFF, 32'h00000003, 32'h00000400, 32'hFFFFFFFC, 32'h00000000, 32'h00000000,
    32'hFFFFFFFC, 32'hFFFFFFFE, 32'h00000000, 32'h00000000, 32'h80000000};
  localparam imm_fmt_e T32_FMT [N32] = '{
    FMT_I, FMT_SHAMT, FMT_I, FMT_B, FMT_NONE, FMT_SHAMT, FMT_S, FMT_J, FMT_SHAMT, FMT_NONE, FMT_U};
  localparam logic T32_ILL [N32] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};

  localparam int N64 = 7;
  localparam logic [31:0] T64_INST [N64] = '{
    32'h80000537, 32'h02009093, 32'hFFF0809B, 32'h43F0D093, 32'h0200909B, 32'hFE000EE3, 32'h4030D09B};
  localparam logic [63:0] T64_IMM [N64] = '{
    64'hFFFFFFFF80000000, 64'h20, 64'hFFFFFFFFFFFFFFFF, 64'h3F, 64'h0, 64'hFFFFFFFFFFFFFFFC, 64'h3};
  localparam imm_fmt_e T64_FMT [N64] = '{
    FMT_U, FMT_SHAMT, FMT_I, FMT_SHAMT, FMT_SHAMT, FMT_B, FMT_SHAMT};
  localparam logic T64_ILL [N64] = '{0, 0, 0, 0, 1, 0, 0};

  localparam logic [31:0] A = 32'hFFF00093;
  localparam logic [31:0] B = 32'hFE000EE3;
  localparam logic [31:0] C = 32'h40000093;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    b32.in_valid = 1'b0; b32.in_inst = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_inst = '0; b64.out_ready = 1'b1;
    step(); step();
    n_chk++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", b32.out_valid); end
    n_chk++; if (b32.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", b32.in_ready); end
    n_chk++; if (b32.out_imm !== 32'h0) begin n_err++; $display("FAIL rst_out_imm: got %h want 0", b32.out_imm); end
    n_chk++; if (b32.out_fmt !== FMT_NONE) begin n_err++; $display("FAIL rst_out_fmt: got %0d want 0", b32.out_fmt); end
    n_chk++; if (b32.out_inst !== 32'h0) begin n_err++; $display("FAIL rst_out_inst: got %h want 0", b32.out_inst); end
    n_chk++; if (b32.out_illegal !== 1'b0) begin n_err++; $display("FAIL rst_out_illegal: got %b want 0", b32.out_illegal); end
    n_chk++; if (b64.out_imm !== 64'h0) begin n_err++; $display("FAIL rst_out_imm64: got %h want 0", b64.out_imm); end
    rst = 1'b0;
    #1;
    n_chk++; if (b32.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", b32.in_ready); end
    n_chk++; if (b64.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready64: got %b want 1", b64.in_ready); end
  endtask

  // One instruction per cycle with out_ready high: each result appears the next cycle.
  task automatic test_decode32();
    for (int i = 0; i < N32; i++) begin
      b32.in_valid = 1'b1; b32.in_inst = T32_INST[i];
      #1;
      n_chk++; if (b32.in_ready !== 1'b1) begin n_err++; $display("FAIL d32_ready[%0d]: got %b want 1", i, b32.in_ready); end
      step();
      n_chk++; if (b32.out_valid !== 1'b1) begin n_err++; $display("FAIL d32_valid[%0d]: got %b want 1", i, b32.out_valid); end
      n_chk++; if (b32.out_imm !== T32_IMM[i]) begin n_err++; $display("FAIL d32_imm[%0d]: got %h want %h", i, b32.out_imm, T32_IMM[i]); end
      n_chk++; if (b32.out_fmt !== T32_FMT[i]) begin n_err++; $display("FAIL d32_fmt[%0d]: got %0d want %0d", i, b32.out_fmt, T32_FMT[i]); end
      n_chk++; if (b32.out_illegal !== T32_ILL[i]) begin n_err++; $display("FAIL d32_ill[%0d]: got %b want %b", i, b32.out_illegal, T32_ILL[i]); end
      n_chk++; if (b32.out_inst !== T32_INST[i]) begin n_err++; $display("FAIL d32_inst[%0d]: got %h want %h", i, b32.out_inst, T32_INST[i]); end
    end
    b32.in_valid = 1'b0;
    step();
    n_chk++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL d32_drain: got %b want 0", b32.out_valid); end
  endtask

  task automatic test_decode64();
    for (int i = 0; i < N64; i++) begin
      b64.in_valid = 1'b1; b64.in_inst = T64_INST[i];
      step();
      n_chk++; if (b64.out_valid !== 1'b1) begin n_err++; $display("FAIL d64_valid[%0d]: got %b want 1", i, b64.out_valid); end
      n_chk++; if (b64.out_imm !== T64_IMM[i]) begin n_err++; $display("FAIL d64_imm[%0d]: got %h want %h", i, b64.out_imm, T64_IMM[i]); end
      n_chk++; if (b64.out_fmt !== T64_FMT[i]) begin n_err++; $display("FAIL d64_fmt[%0d]: got %0d want %0d", i, b64.out_fmt, T64_FMT[i]); end
      n_chk++; if (b64.out_illegal !== T64_ILL[i]) begin n_err++; $display("FAIL d64_ill[%0d]: got %b want %b", i, b64.out_illegal, T64_ILL[i]); end
    end
    b64.in_valid = 1'b0;
    step();
    n_chk++; if (b64.out_valid !== 1'b0) begin n_err++; $display("FAIL d64_drain: got %b want 0", b64.out_valid); end
  endtask

  task automatic test_backpressure();
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.in_inst = A;
    step();
    n_chk++; if (b32.out_inst !== A) begin n_err++; $display("FAIL bp_a_out: got %h want %h", b32.out_inst, A); end
    n_chk++; if (b32.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_a: got %b want 1", b32.in_ready); end
    b32.in_inst = B;
    step();
    n_chk++; if (b32.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_after_b: got %b want 0", b32.in_ready); end
    n_chk++; if (b32.out_inst !== A) begin n_err++; $display("FAIL bp_stall1_inst: got %h want %h", b32.out_inst, A); end
    b32.in_inst = C;
    step();
    n_chk++; if (b32.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_c_held: got %b want 0", b32.in_ready); end
    n_chk++; if (b32.out_inst !== A || b32.out_imm !== 32'hFFFFFFFF || b32.out_fmt !== FMT_I || b32.out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_stall2_stable: got inst=%h imm=%h fmt=%0d v=%b want inst=%h imm=ffffffff fmt=1 v=1", b32.out_inst, b32.out_imm, b32.out_fmt, b32.out_valid, A);
    end
    b32.out_ready = 1'b1;
    step();
    n_chk++; if (b32.out_inst !== B || b32.out_imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL bp_b_out: got %h/%h want %h/fffffffc", b32.out_inst, b32.out_imm, B); end
    n_chk++; if (b32.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_rise: got %b want 1", b32.in_ready); end
    step();
    n_chk++; if (b32.out_inst !== C || b32.out_imm !== 32'h400 || b32.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_c_out: got %h/%h v=%b want %h/00000400 v=1", b32.out_inst, b32.out_imm, b32.out_valid, C); end
    b32.in_valid = 1'b0;
    step();
    n_chk++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", b32.out_valid); end
  endtask

  task automatic test_flush();
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.in_inst = A;
    step();
    b32.in_inst = B;
    step();
    b32.in_inst = C; flush = 1'b1;
    #1;
    n_chk++; if (b32.in_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready_during: got %b want 0", b32.in_ready); end
    step();
    flush = 1'b0;
    #1;
    n_chk++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL fl_out_valid: got %b want 0", b32.out_valid); end
    n_chk++; if (b32.in_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready_after: got %b want 1", b32.in_ready); end
    b32.in_valid = 1'b0; b32.out_ready = 1'b1;
    step();
    n_chk++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL fl_no_stale: got %b want 0", b32.out_valid); end
    // empty pipe: an instruction offered alongside flush must be dropped
    b32.in_valid = 1'b1; b32.in_inst = C; flush = 1'b1;
    #1;
    n_chk++; if (b32.in_ready !== 1'b0) begin n_err++; $display("FAIL fl_empty_ready: got %b want 0", b32.in_ready); end
    step();
    flush = 1'b0; b32.in_valid = 1'b0;
    #1;
    n_chk++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL fl_empty_drop: got %b want 0", b32.out_valid); end
    step();
  endtask

  task automatic test_midreset();
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.in_inst = A;
    step();
    b32.in_inst = B;
    step();
    b32.in_inst = C; rst = 1'b1;
    #1;
    n_chk++; if (b32.in_ready !== 1'b0) begin n_err++; $display("FAIL mr_ready_in_rst: got %b want 0", b32.in_ready); end
    step();
    rst = 1'b0; b32.in_valid = 1'b0;
    #1;
    n_chk++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL mr_out_valid: got %b want 0", b32.out_valid); end
    n_chk++; if (b32.out_imm !== 32'h0 || b32.out_inst !== 32'h0) begin n_err++; $display("FAIL mr_out_data: got %h/%h want 0/0", b32.out_imm, b32.out_inst); end
    n_chk++; if (b32.out_fmt !== FMT_NONE || b32.out_illegal !== 1'b0) begin n_err++; $display("FAIL mr_out_fmt: got %0d/%b want 0/0", b32.out_fmt, b32.out_illegal); end
    n_chk++; if (b32.in_ready !== 1'b1) begin n_err++; $display("FAIL mr_ready: got %b want 1", b32.in_ready); end
    b32.out_ready = 1'b1;
    step();
    n_chk++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL mr_no_stale1: got %b want 0", b32.out_valid); end
    step();
    n_chk++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL mr_no_stale2: got %b want 0", b32.out_valid); end
    b32.in_valid = 1'b1; b32.in_inst = 32'h4030D093;
    step();
    b32.in_valid = 1'b0;
    n_chk++; if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'h3 || b32.out_fmt !== FMT_SHAMT) begin
      n_err++; $display("FAIL mr_resume: got v=%b imm=%h fmt=%0d want v=1 imm=00000003 fmt=6", b32.out_valid, b32.out_imm, b32.out_fmt);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_decode32();
    test_decode64();
    test_backpressure();
    test_flush();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
